// File: rtl/mem_pkg.sv
// mem_pkg: constants and types shared by the data memory responder slice.
//   - funct3 encodings for RISC-V load/store sizes
//   - FSM state type for the responder handshake
//   - word and address widths
package mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for one load/store access.
// Ports:
//   funct3        in   access size/sign (RISC-V load/store funct3)
//   we            in   1 = store, 0 = load
//   addr_lo       in   byte offset within the word (addr[1:0])
//   wdata         in   right-aligned store data
//   rdata_word    in   full word read from storage
//   byte_en       out  per-lane store enable (zero when align_err)
//   wdata_aligned out  store data replicated onto its target lanes
//   load_data     out  sign/zero-extended load result
//   align_err     out  misaligned access or illegal funct3 for the direction
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic              we,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rdata_word,
    output logic [3:0]        byte_en,
    output logic [WORD_W-1:0] wdata_aligned,
    output logic [WORD_W-1:0] load_data,
    output logic              align_err
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = rdata_word[{addr_lo, 3'b000} +: 8];
        sel_half = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
    end

    always_comb begin
        byte_en       = '0;
        wdata_aligned = '0;
        load_data     = '0;
        align_err     = 1'b0;
        case (funct3)
            F3_B: begin
                byte_en       = 4'b0001 << addr_lo;
                wdata_aligned = {4{wdata[7:0]}};
                load_data     = {{24{sel_byte[7]}}, sel_byte};
            end
            F3_BU: begin
                // unsigned sizes exist only for loads
                align_err = we;
                load_data = {24'd0, sel_byte};
            end
            F3_H: begin
                align_err     = addr_lo[0];
                byte_en       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_aligned = {2{wdata[15:0]}};
                load_data     = {{16{sel_half[15]}}, sel_half};
            end
            F3_HU: begin
                align_err = we | addr_lo[0];
                load_data = {16'd0, sel_half};
            end
            F3_W: begin
                align_err     = (addr_lo != 2'b00);
                byte_en       = 4'b1111;
                wdata_aligned = wdata;
                load_data     = rdata_word;
            end
            default: begin
                align_err = 1'b1;
            end
        endcase
        if (align_err) begin
            byte_en = '0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the core load/store interface.
// Word-organised storage with byte-lane writes, RISC-V load extension,
// WAIT_STATES inserted cycles and error flagging (misaligned, out of range,
// illegal funct3). Optional access counters under `DMEM_ACCESS_CNT_EN.
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   req_valid/req_ready request handshake
//   req_we, req_funct3  direction and size
//   req_addr, req_wdata byte address and right-aligned store data
//   rsp_valid           one-cycle response pulse
//   rsp_rdata, rsp_err  extended load data (0 for stores/errors), error flag
//   load_count, store_count (DMEM_ACCESS_CNT_EN only) successful access counts
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0]       load_count,
    output logic [31:0]       store_count
`endif
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
    localparam logic        ZERO_WAIT = (WAIT_STATES == 0);

    state_t            state;
    logic [3:0]        wait_cnt;

    logic              lat_we;
    logic [2:0]        lat_funct3;
    logic [ADDR_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    logic              cur_we;
    logic [2:0]        cur_funct3;
    logic [ADDR_W-1:0] cur_addr;
    logic [WORD_W-1:0] cur_wdata;

    logic [29:0]       word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              range_err;
    logic [WORD_W-1:0] rd_word;
    logic [3:0]        byte_en;
    logic [WORD_W-1:0] wdata_aligned;
    logic [WORD_W-1:0] load_data;
    logic              align_err;
    logic              access_err;
    logic              commit;
    logic              mem_we;

    // With zero wait states the commit edge is the acceptance edge, so the
    // access must be evaluated on the live request rather than the latch.
    always_comb begin
        if (state == IDLE) begin
            cur_we     = req_we;
            cur_funct3 = req_funct3;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata;
        end else begin
            cur_we     = lat_we;
            cur_funct3 = lat_funct3;
            cur_addr   = lat_addr;
            cur_wdata  = lat_wdata;
        end
    end

    always_comb begin
        word_idx  = cur_addr[31:2];
        mem_idx   = word_idx[IDX_W-1:0];
        range_err = ({2'b00, word_idx} >= DEPTH_WORDS);
        rd_word   = range_err ? '0 : mem[mem_idx];
    end

    mem_lane_align u_lane_align (
        .funct3        (cur_funct3),
        .we            (cur_we),
        .addr_lo       (cur_addr[1:0]),
        .wdata         (cur_wdata),
        .rdata_word    (rd_word),
        .byte_en       (byte_en),
        .wdata_aligned (wdata_aligned),
        .load_data     (load_data),
        .align_err     (align_err)
    );

    always_comb begin
        access_err = range_err | align_err;
        commit     = rst && ((state == IDLE && req_valid && ZERO_WAIT) ||
                             (state == WAIT && wait_cnt == 4'd1));
        mem_we     = commit && cur_we && !access_err;
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[mem_idx][8*i +: 8] <= wdata_aligned[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            lat_we     <= req_we;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            rsp_valid <= commit;
            rsp_err   <= commit && access_err;
            rsp_rdata <= (commit && !access_err && !cur_we) ? load_data : '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wait_cnt  <= WAIT_INIT;
                        req_ready <= 1'b0;
                        state     <= ZERO_WAIT ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            load_count  <= '0;
            store_count <= '0;
        end else if (state == RESP && !rsp_err) begin
            if (lat_we) begin
                store_count <= store_count + 32'd1;
            end else begin
                load_count <= load_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst       [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [2:0]  req_funct3[2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] load_count [2];
    logic [31:0] store_count[2];
    int unsigned exp_loads  [2];
    int unsigned exp_stores [2];
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [7:0] mmem [2][DEPTH*4];

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut_ws2 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
`ifdef DMEM_ACCESS_CNT_EN
        , .load_count(load_count[0]), .store_count(store_count[0])
`endif
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
`ifdef DMEM_ACCESS_CNT_EN
        , .load_count(load_count[1]), .store_count(store_count[1])
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // Reference: byte-addressed memory, size/sign from funct3, plain arithmetic.
    task automatic model_access(input int d, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd);
        int unsigned size;
        bit          sgn;
        bit          legal;
        logic [31:0] val;
        legal = 1'b1;
        sgn   = 1'b0;
        size  = 1;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; end
            3'd4: begin size = 1; legal = !we; end
            3'd5: begin size = 2; legal = !we; end
            default: legal = 1'b0;
        endcase
        err = !legal || (addr % size != 0) || (addr / 4 >= DEPTH);
        rd  = '0;
        if (!err) begin
            if (we) begin
                for (int unsigned i = 0; i < size; i++) mmem[d][addr + i] = wd[8*i +: 8];
            end else begin
                val = '0;
                for (int unsigned i = 0; i < size; i++) val = val | (32'(mmem[d][addr + i]) << (8*i));
                if (sgn && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8*size)) - 32'd1);
                rd = val;
            end
`ifdef DMEM_ACCESS_CNT_EN
            if (we) exp_stores[d]++; else exp_loads[d]++;
`endif
        end
    endtask

    task automatic access(input int d, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int unsigned n;
        int unsigned lat;
        model_access(d, we, f3, addr, wd, exp_err, exp_rd);
        @(negedge clk);
        req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
        req_addr[d] = addr; req_wdata[d] = wd;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check_eq("accept_wait", 32'(n), 32'd0);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (rsp_valid[d] !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
        check_eq("latency", 32'(lat), 32'(ws_of(d) + 1));
        rd  = rsp_rdata[d];
        err = rsp_err[d];
        check_eq("rdata", rd, exp_rd);
        check_eq("err", 32'(err), 32'(exp_err));
        check_eq("ready_in_resp", 32'(req_ready[d]), 32'd0);
        @(negedge clk);
        check_eq("pulse_width", 32'(rsp_valid[d]), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; req_valid[d] = 1'b0; req_we[d] = 1'b0;
            req_funct3[d] = 3'd0; req_addr[d] = '0; req_wdata[d] = '0;
`ifdef DMEM_ACCESS_CNT_EN
            exp_loads[d] = 0; exp_stores[d] = 0;
`endif
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b1; rst[1] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("reset_ready", 32'(req_ready[d]), 32'd1);
            check_eq("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check_eq("reset_rdata", rsp_rdata[d], 32'd0);
            check_eq("reset_err", 32'(rsp_err[d]), 32'd0);
        end

        // Define every word so the model and storage agree.
        for (int d = 0; d < 2; d++)
            for (int unsigned w = 0; w < DEPTH; w++)
                access(d, 1'b1, 3'd2, 32'(w * 4), $urandom, rd, err);

        // Directed cases on the WAIT_STATES = 2 instance.
        access(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, rd, err);
        check_eq("sw_rdata", rd, 32'd0);
        access(0, 1'b0, 3'd2, 32'h10, 32'h0, rd, err);
        check_eq("lw_10", rd, 32'hDEADBEEF);
        access(0, 1'b1, 3'd2, 32'h20, 32'h11223344, rd, err);
        access(0, 1'b1, 3'd0, 32'h21, 32'h000000AB, rd, err);
        access(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, err);
        check_eq("sb_merge", rd, 32'h1122AB44);
        access(0, 1'b0, 3'd0, 32'h21, 32'h0, rd, err);
        check_eq("lb_sext", rd, 32'hFFFFFFAB);
        access(0, 1'b0, 3'd4, 32'h21, 32'h0, rd, err);
        check_eq("lbu_zext", rd, 32'h000000AB);
        access(0, 1'b1, 3'd1, 32'h22, 32'h00008001, rd, err);
        access(0, 1'b0, 3'd1, 32'h22, 32'h0, rd, err);
        check_eq("lh_sext", rd, 32'hFFFF8001);
        access(0, 1'b0, 3'd5, 32'h22, 32'h0, rd, err);
        check_eq("lhu_zext", rd, 32'h00008001);
        access(0, 1'b0, 3'd2, 32'h13, 32'h0, rd, err);
        check_eq("lw_misalign_err", 32'(err), 32'd1);
        check_eq("lw_misalign_rdata", rd, 32'd0);
        access(0, 1'b1, 3'd2, 32'h30, 32'h12345678, rd, err);
        access(0, 1'b1, 3'd1, 32'h31, 32'h0000FFFF, rd, err);
        check_eq("sh_misalign_err", 32'(err), 32'd1);
        access(0, 1'b0, 3'd2, 32'h30, 32'h0, rd, err);
        check_eq("sh_misalign_nowrite", rd, 32'h12345678);
        access(0, 1'b0, 3'd2, 32'(4 * DEPTH), 32'h0, rd, err);
        check_eq("lw_range_err", 32'(err), 32'd1);
        access(0, 1'b0, 3'd3, 32'h30, 32'h0, rd, err);
        check_eq("ld_f3_err", 32'(err), 32'd1);
        access(0, 1'b1, 3'd4, 32'h30, 32'h0, rd, err);
        check_eq("sbu_err", 32'(err), 32'd1);

        // Back-to-back with request held on the zero-wait instance.
        model_access(1, 1'b0, 3'd2, 32'h20, 32'h0, exp_err, exp_rd);
        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'd2;
        req_addr[1] = 32'h20; req_wdata[1] = '0;
        #1;
        for (int k = 0; k < 8; k++) begin
            check_eq("b2b_ready", 32'(req_ready[1]), (k % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("b2b_rsp", 32'(rsp_valid[1]), (k % 2 == 1) ? 32'd1 : 32'd0);
            if (k % 2 == 1) check_eq("b2b_rdata", rsp_rdata[1], exp_rd);
            if (k < 7) begin @(negedge clk); #1; end
        end
        req_valid[1] = 1'b0;
        @(negedge clk);
        check_eq("b2b_idle", 32'(req_ready[1]), 32'd1);
`ifdef DMEM_ACCESS_CNT_EN
        exp_loads[1] += 3;
`endif

        // Reset during WAIT drops an uncommitted store.
        access(0, 1'b1, 3'd2, 32'h40, 32'h0, rd, err);
        access(0, 1'b0, 3'd2, 32'h40, 32'h0, rd, err);
        check_eq("pre_rst_lw", rd, 32'd0);
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'd2;
        req_addr[0] = 32'h40; req_wdata[0] = 32'h55;
        @(negedge clk);
        req_valid[0] = 1'b0;
        rst[0] = 1'b0;
        @(negedge clk);
        rst[0] = 1'b1;
`ifdef DMEM_ACCESS_CNT_EN
        exp_loads[0] = 0; exp_stores[0] = 0;
`endif
        check_eq("rst_ready", 32'(req_ready[0]), 32'd1);
        check_eq("rst_rsp", 32'(rsp_valid[0]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("rst_no_rsp", 32'(rsp_valid[0]), 32'd0);
        end
        access(0, 1'b0, 3'd2, 32'h40, 32'h0, rd, err);
        check_eq("rst_no_store", rd, 32'd0);

        // Random mix against the byte model.
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 60; t++) begin
                we   = 1'($urandom_range(0, 1));
                f3   = 3'($urandom_range(0, 7));
                addr = ($urandom_range(0, 7) == 0) ? 32'((DEPTH + $urandom_range(0, 15)) * 4)
                                                   : 32'($urandom_range(0, DEPTH - 1) * 4);
                addr = addr + 32'($urandom_range(0, 3));
                access(d, we, f3, addr, $urandom, rd, err);
            end
        end

`ifdef DMEM_ACCESS_CNT_EN
        for (int d = 0; d < 2; d++) begin
            check_eq("load_count", load_count[d], 32'(exp_loads[d]));
            check_eq("store_count", store_count[d], 32'(exp_stores[d]));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
